// File: rtl/sd_arbiter.sv
// Two-client arbiter for the shared SD card controller: one-hot registered grants,
// round-robin on ties, clean release at sector boundaries and idle-owner revocation.
module sd_arbiter #(
    parameter int unsigned   TW             = 24,
    parameter logic [TW-1:0] TIMEOUT_CYCLES = TW'(24'd10_000_000)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sd_ready,
    input  logic [7:0]  sd_dout,
    input  logic        sd_byte_available,
    input  logic        sd_ready_for_next_byte,
    output logic [31:0] sd_address,
    output logic        sd_rd,
    output logic        sd_wr,
    output logic [7:0]  sd_din,
    input  logic        c0_req,
    output logic        c0_gnt,
    input  logic [31:0] c0_address,
    input  logic        c0_rd,
    input  logic        c0_wr,
    input  logic [7:0]  c0_din,
    output logic [7:0]  c0_dout,
    output logic        c0_ready,
    output logic        c0_byte_available,
    output logic        c0_ready_for_next_byte,
    input  logic        c1_req,
    output logic        c1_gnt,
    input  logic [31:0] c1_address,
    input  logic        c1_rd,
    input  logic        c1_wr,
    input  logic [7:0]  c1_din,
    output logic [7:0]  c1_dout,
    output logic        c1_ready,
    output logic        c1_byte_available,
    output logic        c1_ready_for_next_byte,
    output logic        timeout
);

    typedef enum logic [1:0] {ST_BOOT, ST_IDLE, ST_OWN, ST_DRAIN} state_t;

    localparam logic [TW-1:0] TO_LAST = TIMEOUT_CYCLES - TW'(1'b1);

    state_t        state_r;
    logic          last_owner_r;
    logic [TW-1:0] cnt_r;
    logic          own_req_s;
    logic          own_cmd_s;

    // Request and command activity of whichever client currently owns the controller.
    always_comb begin
        own_req_s = 1'b0;
        own_cmd_s = 1'b0;
        if (c1_gnt) begin
            own_req_s = c1_req;
            own_cmd_s = c1_rd | c1_wr;
        end else begin
            own_req_s = c0_req;
            own_cmd_s = c0_rd | c0_wr;
        end
    end

    // Arbitration FSM; grants, timeout pulse and idle counter are all registered here.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r      <= ST_BOOT;
            c0_gnt       <= 1'b0;
            c1_gnt       <= 1'b0;
            timeout      <= 1'b0;
            cnt_r        <= '0;
            last_owner_r <= 1'b1;
        end else begin
            timeout <= 1'b0;
            case (state_r)
                ST_BOOT: begin
                    if (sd_ready) state_r <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (sd_ready && (c0_req || c1_req)) begin
                        // client 0 wins alone, or on a tie when client 1 went last
                        if (c0_req && (!c1_req || last_owner_r)) begin
                            c0_gnt       <= 1'b1;
                            last_owner_r <= 1'b0;
                        end else begin
                            c1_gnt       <= 1'b1;
                            last_owner_r <= 1'b1;
                        end
                        cnt_r   <= '0;
                        state_r <= ST_OWN;
                    end
                end
                ST_OWN: begin
                    if (!own_req_s) begin
                        c0_gnt  <= 1'b0;
                        c1_gnt  <= 1'b0;
                        cnt_r   <= '0;
                        state_r <= sd_ready ? ST_IDLE : ST_DRAIN;
                    end else if ((TIMEOUT_CYCLES != '0) && sd_ready && !own_cmd_s) begin
                        if (cnt_r == TO_LAST) begin
                            c0_gnt  <= 1'b0;
                            c1_gnt  <= 1'b0;
                            timeout <= 1'b1;
                            cnt_r   <= '0;
                            state_r <= ST_IDLE;
                        end else begin
                            cnt_r <= cnt_r + TW'(1'b1);
                        end
                    end else begin
                        cnt_r <= '0;
                    end
                end
                ST_DRAIN: begin
                    if (sd_ready) state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_BOOT;
                    c0_gnt  <= 1'b0;
                    c1_gnt  <= 1'b0;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

    // Route the owner's command/data to the controller and gate status back to it only.
    always_comb begin
        sd_address             = 32'd0;
        sd_din                 = 8'd0;
        sd_rd                  = 1'b0;
        sd_wr                  = 1'b0;
        c0_dout                = 8'd0;
        c0_ready               = 1'b0;
        c0_byte_available      = 1'b0;
        c0_ready_for_next_byte = 1'b0;
        c1_dout                = 8'd0;
        c1_ready               = 1'b0;
        c1_byte_available      = 1'b0;
        c1_ready_for_next_byte = 1'b0;
        if (c0_gnt) begin
            sd_address             = c0_address;
            sd_din                 = c0_din;
            sd_wr                  = c0_wr;
            sd_rd                  = c0_rd & ~c0_wr;
            c0_dout                = sd_dout;
            c0_ready               = sd_ready;
            c0_byte_available      = sd_byte_available;
            c0_ready_for_next_byte = sd_ready_for_next_byte;
        end else if (c1_gnt) begin
            sd_address             = c1_address;
            sd_din                 = c1_din;
            sd_wr                  = c1_wr;
            sd_rd                  = c1_rd & ~c1_wr;
            c1_dout                = sd_dout;
            c1_ready               = sd_ready;
            c1_byte_available      = sd_byte_available;
            c1_ready_for_next_byte = sd_ready_for_next_byte;
        end else begin
            sd_address = 32'd0;
        end
    end

endmodule
